// File: rtl/group_scan_pkg.sv
// group_scan_pkg: shared states, targets, decode bit positions and default widths for the group scan bridge.
package group_scan_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {TGT_SRAM, TGT_CR, TGT_SR} tgt_t;
    localparam int SEL_MEM_BIT     = 11;
    localparam int SEL_SR_BIT      = 10;
    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SRAM_AW     = 11;
    localparam int DEF_CR_W        = 17;
    localparam int DEF_SR_W        = 15;
    localparam int DEF_SEG_W       = 4;
    localparam int DEF_TIMEOUT_CYC = 255;
    function automatic tgt_t decode_tgt(input logic [11:0] a);
        tgt_t t;
        t = TGT_CR;
        if (!a[SEL_MEM_BIT]) t = TGT_SRAM;
        else if (a[SEL_SR_BIT]) t = TGT_SR;
        return t;
    endfunction
endpackage

// File: rtl/scan_id_sync_pulse.sv
// scan_id_sync_pulse: two-flop synchroniser for scan_id with a one-cycle pulse on each rising edge.
module scan_id_sync_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic scan_id,
    output logic id_valid
);
    logic sync1, sync2, prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {sync1, sync2, prev} <= '0;
        else        {sync1, sync2, prev} <= {scan_id, sync1, sync2};
    end
    assign id_valid = sync2 & ~prev;
endmodule

// File: rtl/group_scan_bridge_param.sv
// group_scan_bridge_param: turns scan-ID-qualified static requests into single SRAM or CR/SR transactions.
// Define SCAN_BRIDGE_TIMEOUT_EN to abort an access with an error after TIMEOUT_CYC cycles without ready.
module group_scan_bridge_param
    import group_scan_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SRAM_AW     = DEF_SRAM_AW,
    parameter int CR_W        = DEF_CR_W,
    parameter int SR_W        = DEF_SR_W,
    parameter int SEG_W       = DEF_SEG_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_id,
    input  logic              static_wen,
    input  logic              static_ren,
    input  logic [ADDR_W-1:0] static_addr,
    input  logic [DATA_W-1:0] static_wdata,
    output logic [DATA_W-1:0] static_rdata,
    output logic              static_ready,
    output logic              static_err,
    output logic              static_overrun,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready,
    output logic              reg_ren,
    output logic              reg_wen,
    output logic [CR_W-1:0]   cr_wdata,
    input  logic [CR_W-1:0]   cr_rdata,
    input  logic [SR_W-1:0]   sr_rdata,
    input  logic              reg_ready,
    output logic [SEG_W-1:0]  seg_id,
    output logic              id_sel
);
    state_t state, state_n;
    tgt_t tgt, tgt_n;
    logic id_valid, take, bad, rdy, tmo, ok, acc_n, c_ren, c_wen;
    logic sram_ren_n, sram_wen_n, reg_ren_n, reg_wen_n;
    logic ren_q, wen_q;
    logic [11:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rd_sel;
    logic unused_addr_hi;

    scan_id_sync_pulse u_sync (.clk(clk), .rst_n(rst_n), .scan_id(scan_id), .id_valid(id_valid));

    assign unused_addr_hi = ^static_addr[ADDR_W-1:12];
    assign take = (state == IDLE) && id_valid;
    assign bad = (static_ren & static_wen) | (static_wen & static_addr[SEL_MEM_BIT] & static_addr[SEL_SR_BIT]);
    assign tgt = decode_tgt(addr_q);
    assign rdy = (tgt == TGT_SRAM) ? sram_ready : reg_ready;
    assign ok = (state == ACCESS) && rdy;

`ifdef SCAN_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;
    // Counter sits at zero outside ACCESS, so every access starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (state != ACCESS) cnt <= '0;
        else if (!rdy) cnt <= cnt + 1'b1;
    end
    assign tmo = !rdy && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE)   ? ((take && (static_ren || static_wen)) ? (bad ? RESP : ACCESS) : IDLE) :
                  (state == ACCESS) ? ((rdy || tmo) ? RESP : ACCESS) : IDLE;
        c_ren = take ? static_ren : ren_q;
        c_wen = take ? static_wen : wen_q;
        tgt_n = decode_tgt(take ? static_addr[11:0] : addr_q);
        acc_n = (state_n == ACCESS);
        sram_ren_n = acc_n && c_ren && (tgt_n == TGT_SRAM);
        sram_wen_n = acc_n && c_wen && (tgt_n == TGT_SRAM);
        reg_ren_n = acc_n && c_ren && (tgt_n != TGT_SRAM);
        reg_wen_n = acc_n && c_wen && (tgt_n == TGT_CR);
        rd_sel = wen_q ? '0 : (tgt == TGT_SRAM) ? sram_rdata :
                 (tgt == TGT_CR) ? DATA_W'(cr_rdata) : DATA_W'(sr_rdata);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ren_q, wen_q, sram_ren, sram_wen, reg_ren, reg_wen, static_err} <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            static_rdata <= '0;
        end else begin
            if (take) begin
                ren_q   <= static_ren;
                wen_q   <= static_wen;
                addr_q  <= static_addr[11:0];
                wdata_q <= static_wdata;
            end
            sram_ren <= sram_ren_n;
            sram_wen <= sram_wen_n;
            reg_ren  <= reg_ren_n;
            reg_wen  <= reg_wen_n;
            // Error paths (rejected request or timeout) always return zero data.
            if (state_n == RESP) begin
                static_err   <= !ok;
                static_rdata <= ok ? rd_sel : '0;
            end
        end
    end

    assign static_ready   = (state == RESP);
    assign static_overrun = id_valid && (state != IDLE);
    assign sram_addr      = addr_q[SRAM_AW-1:0];
    assign sram_wdata     = wdata_q;
    assign cr_wdata       = wdata_q[CR_W-1:0];
    assign seg_id         = addr_q[SEG_W-1:0];
    assign id_sel         = addr_q[SEL_SR_BIT];
endmodule

// File: tb/tb_group_scan_bridge_param.sv
// tb_group_scan_bridge_param: scoreboard bench with randomized requests and behavioural SRAM/register models.
module tb_group_scan_bridge_param;
    localparam int AW = 20, DW = 32, SAW = 11, CRW = 17, SRW = 15, SGW = 4, TO = 4;
`ifdef SCAN_BRIDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 0, rst_n = 0, scan_id = 0, static_wen = 0, static_ren = 0;
    logic [AW-1:0] static_addr = '0;
    logic [DW-1:0] static_wdata = '0, static_rdata, sram_wdata, sram_rdata = '0;
    logic static_ready, static_err, static_overrun, sram_ren, sram_wen, reg_ren, reg_wen, id_sel;
    logic sram_ready = 0, reg_ready = 0;
    logic [SAW-1:0] sram_addr;
    logic [CRW-1:0] cr_wdata, cr_rdata;
    logic [SRW-1:0] sr_rdata = '0;
    logic [SGW-1:0] seg_id;

    group_scan_bridge_param #(.ADDR_W(AW), .DATA_W(DW), .SRAM_AW(SAW), .CR_W(CRW), .SR_W(SRW),
                              .SEG_W(SGW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .scan_id(scan_id), .static_wen(static_wen), .static_ren(static_ren),
        .static_addr(static_addr), .static_wdata(static_wdata), .static_rdata(static_rdata),
        .static_ready(static_ready), .static_err(static_err), .static_overrun(static_overrun),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready), .reg_ren(reg_ren), .reg_wen(reg_wen),
        .cr_wdata(cr_wdata), .cr_rdata(cr_rdata), .sr_rdata(sr_rdata), .reg_ready(reg_ready),
        .seg_id(seg_id), .id_sel(id_sel));

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
    typedef struct { int tgt; logic wr; logic [10:0] idx; logic [31:0] wd; } acc_t;
    resp_t exp_q[$];
    acc_t acc_q[$];
    resp_t mon_e;
    acc_t ra;
    int total = 0, bad = 0, ovr_seen = 0, ovr_exp = 0, next_lat = 0, cyc = 0;
    bit [31:0] model_mem [2048];
    bit [31:0] resp_mem [2048];
    bit [16:0] model_cr = '0, resp_cr = '0;

    assign cr_rdata = resp_cr;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every completion is matched against the oldest expected response.
    always @(negedge clk) begin
        if (static_overrun) ovr_seen++;
        if (static_ready) begin
            if (exp_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("rdata", static_rdata, mon_e.rdata);
                chk("err", 32'(static_err), 32'(mon_e.err));
                chk("latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Target responder: checks each new access against the expected one and answers after next_lat cycles.
    initial begin
        bit active;
        int lat;
        logic [3:0] exp4;
        active = 0;
        lat = 0;
        forever begin
            @(negedge clk);
            sram_ready = 0;
            reg_ready = 0;
            sram_rdata = $urandom;
            if (!(sram_ren | sram_wen | reg_ren | reg_wen)) begin
                active = 0;
                if ($urandom_range(3) == 0) begin sram_ready = 1; reg_ready = 1; end
            end else begin
                if (!active) begin
                    active = 1;
                    lat = next_lat;
                    if (acc_q.size() == 0) chk("spurious_strobe", 32'd1, 32'd0);
                    else begin
                        ra = acc_q.pop_front();
                        exp4 = (ra.tgt == 0) ? {~ra.wr, ra.wr, 2'b00} : {2'b00, ~ra.wr, ra.wr};
                        chk("strobes", 32'({sram_ren, sram_wen, reg_ren, reg_wen}), 32'(exp4));
                        if (ra.tgt == 0) begin
                            chk("sram_addr", 32'(sram_addr), 32'(ra.idx));
                            if (ra.wr) chk("sram_wdata", sram_wdata, ra.wd);
                        end else begin
                            chk("seg_id", 32'(seg_id), 32'(ra.idx[3:0]));
                            chk("id_sel", 32'(id_sel), 32'(ra.tgt == 2));
                            if (ra.wr) chk("cr_wdata", 32'(cr_wdata), 32'(ra.wd[16:0]));
                        end
                    end
                end
                if (lat == 0) begin
                    active = 0;
                    if (ra.tgt == 0) begin
                        sram_ready = 1;
                        if (ra.wr) resp_mem[sram_addr] = sram_wdata;
                        else sram_rdata = resp_mem[sram_addr];
                    end else begin
                        reg_ready = 1;
                        if (ra.wr) resp_cr = cr_wdata;
                    end
                end else begin
                    lat--;
                    if (ra.tgt == 0) reg_ready = 1'($urandom);
                    else sram_ready = 1'($urandom);
                end
            end
        end
    end

    task automatic scan_pulse();
        scan_id = 1;
        repeat (2) @(negedge clk);
        scan_id = 0;
        repeat (2) @(negedge clk);
    endtask

    // Reference model: decides the outcome from the request alone, then raises scan_id.
    task automatic issue(input logic r, input logic w, input logic [19:0] ad, input logic [31:0] wd,
                         input int lat, input logic [14:0] sr);
        resp_t e;
        acc_t a;
        int tgt;
        logic [10:0] idx;
        @(negedge clk);
        static_ren = r; static_wen = w; static_addr = ad; static_wdata = wd; sr_rdata = sr; next_lat = lat;
        tgt = !ad[11] ? 0 : ad[10] ? 2 : 1;
        idx = (tgt == 0) ? ad[10:0] : {7'b0, ad[3:0]};
        if (r | w) begin
            if ((r & w) || (w && tgt == 2)) begin
                e.rdata = 0; e.err = 1; e.cyc = cyc + 3;
            end else begin
                a.tgt = tgt; a.wr = w; a.idx = idx; a.wd = wd;
                acc_q.push_back(a);
                if (TMO_EN && lat >= TO) begin
                    e.rdata = 0; e.err = 1; e.cyc = cyc + 3 + TO;
                end else begin
                    e.err = 0; e.cyc = cyc + 4 + lat;
                    e.rdata = w ? 32'd0 : (tgt == 0) ? model_mem[idx] : (tgt == 1) ? 32'(model_cr) : 32'(sr);
                    if (w && tgt == 0) model_mem[idx] = wd;
                    if (w && tgt == 1) model_cr = wd[16:0];
                end
            end
            exp_q.push_back(e);
        end
        scan_pulse();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            chk("response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic txn(input logic r, input logic w, input logic [19:0] ad, input logic [31:0] wd,
                       input int lat, input logic [14:0] sr);
        issue(r, w, ad, wd, lat, sr);
        wait_done();
    endtask

    initial begin
        logic [19:0] ad;
        int op;
        repeat (3) @(negedge clk);
        chk("rst_rdata", static_rdata, 32'd0);
        chk("rst_ctrl", 32'({static_ready, static_err, static_overrun, sram_ren, sram_wen, reg_ren, reg_wen,
                             id_sel, seg_id, sram_addr}), 32'd0);
        chk("rst_wdata", sram_wdata | 32'(cr_wdata), 32'd0);
        rst_n = 1;
        txn(0, 1, 20'hF0005, 32'hA5A5_1234, 0, 15'h0);
        txn(1, 0, 20'h00005, 32'h0, 1, 15'h0);
        txn(0, 1, 20'h00803, 32'h0001_ABCD, 0, 15'h0);
        txn(1, 0, 20'h00803, 32'h0, 2, 15'h0);
        txn(1, 0, 20'h00C02, 32'h0, 0, 15'h7FFF);
        txn(0, 1, 20'h00C02, 32'h1234_5678, 0, 15'h7FFF);
        txn(1, 1, 20'h00010, 32'hDEAD_BEEF, 0, 15'h0);
        txn(0, 0, 20'h00010, 32'hDEAD_BEEF, 0, 15'h0);
        // Second scan_id rise lands while the first access is still waiting on the SRAM.
        issue(1, 0, 20'h00005, 32'h0, 10, 15'h0);
        ovr_exp++;
        static_ren = 1; static_wen = 0; static_addr = 20'h00007;
        scan_pulse();
        wait_done();
        chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
        if (TMO_EN) begin
            txn(1, 0, 20'h00005, 32'h0, 100, 15'h0);
            txn(1, 0, 20'h00005, 32'h0, TO - 1, 15'h0);
        end
        // Asynchronous reset while the SRAM strobe is high: strobe falls at once, no response follows.
        issue(1, 0, 20'h00006, 32'h0, 20, 15'h0);
        #2 rst_n = 0;
        #1 chk("rst_async_strobe", 32'({sram_ren, sram_wen, reg_ren, reg_wen}), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("rst_mid_ready", 32'(static_ready), 32'd0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        txn(1, 0, 20'h00005, 32'h0, 0, 15'h0);
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            ad = 20'($urandom);
            ad[9:3] = '0;
            txn(op == 1 || (op >= 2 && op <= 5), op == 1 || op >= 6, ad, $urandom, $urandom_range(0, 5),
                15'($urandom));
        end
        chk("acc_left", 32'(acc_q.size()), 32'd0);
        chk("overrun_final", 32'(ovr_seen), 32'(ovr_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
